// File: rtl/jxj_rx_pkg.sv
// Shared types and constants for the jxj_rx_fifo store-and-forward buffer.
package jxj_rx_pkg;

  // One RAM word: payload byte plus end-of-packet marker.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } rx_entry_t;

  // Read-side sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    SEND,
    END,
    GAP
  } rx_state_t;

  // Width of the inter-packet gap counter (GAP up to 15).
  localparam int unsigned GAP_W = 4;

endpackage

// File: rtl/jxj_rx_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// Contents are not reset; the FIFO pointers decide what is valid.
module jxj_rx_dpram
  import jxj_rx_pkg::*;
#(
  parameter int unsigned AW = 11
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  rx_entry_t     i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output rx_entry_t     o_rdata
);

  rx_entry_t r_mem [0:(1<<AW)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/jxj_rx_fifo.sv
// Store-and-forward packet buffer between the link receive byte stream and
// jxj_gate. A packet is only released once it has been received complete;
// packets that overflow the buffer are discarded whole.
// Optional macro JXJ_RX_FIFO_DROP_CNT_EN adds the drop_count port/counter.
module jxj_rx_fifo #(
  parameter int unsigned AW  = 11,
  parameter int unsigned GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_stb,
  input  logic       in_end,
  output logic [7:0] out_data,
  output logic       out_stb,
  output logic       out_end,
  output logic       overflow
`ifdef JXJ_RX_FIFO_DROP_CNT_EN
  ,
  output logic [7:0] drop_count
`endif
);

  import jxj_rx_pkg::*;
  // The GAP parameter shadows the package state literal, so that state is
  // always written fully qualified as jxj_rx_pkg::GAP.

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [AW-1:0]    r_wr_ptr, r_wr_base, r_rd_ptr;
  logic [AW:0]      r_pkt_cnt;
  logic             r_ovf_flag;
  logic [7:0]       r_last_data;
  logic [GAP_W-1:0] r_gap_cnt;
  rx_state_t        r_state, w_state_nxt;

  logic [AW-1:0] w_wr_ptr_inc, w_waddr;
  logic          w_full, w_wr_acc, w_ovf, w_has_bytes;
  logic          w_commit, w_discard, w_fix, w_we;
  rx_entry_t     w_wdata, w_rdata;
  logic          w_rd_en, w_pop, w_stb_nxt, w_end_nxt;

  // Write-side decode: accept, overflow detection, commit and discard.
  always_comb begin
    w_wr_ptr_inc = r_wr_ptr + PTR_ONE;
    w_full       = (w_wr_ptr_inc == r_rd_ptr);
    w_wr_acc     = in_stb & ~w_full;
    w_ovf        = r_ovf_flag | (in_stb & w_full);
    w_has_bytes  = w_wr_acc | (r_wr_ptr != r_wr_base);
    w_commit     = in_end & ~w_ovf & w_has_bytes;
    w_discard    = in_end & w_ovf;
    // in_end without a byte: re-write the previous entry with last set.
    w_fix        = w_commit & ~in_stb;
    w_we         = w_wr_acc | w_fix;
    w_waddr      = w_fix ? (r_wr_ptr - PTR_ONE) : r_wr_ptr;
    w_wdata      = w_fix ? rx_entry_t'({1'b1, r_last_data})
                         : rx_entry_t'({in_end, in_data});
  end

  jxj_rx_dpram #(
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Write pointers, overflow tracking and the discard pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_wr_base   <= '0;
      r_ovf_flag  <= 1'b0;
      r_last_data <= '0;
      overflow    <= 1'b0;
    end else begin
      if (w_discard)     r_wr_ptr <= r_wr_base;
      else if (w_wr_acc) r_wr_ptr <= w_wr_ptr_inc;
      if (w_commit)      r_wr_base <= w_wr_acc ? w_wr_ptr_inc : r_wr_ptr;
      if (w_wr_acc)      r_last_data <= in_data;
      if (w_discard)             r_ovf_flag <= 1'b0;
      else if (in_stb && w_full) r_ovf_flag <= 1'b1;
      overflow <= w_discard;
    end
  end

  // Committed-packet count: commit and final-byte pop in one cycle cancel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pkt_cnt <= '0;
    end else begin
      case ({w_commit, w_pop})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + CNT_ONE;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - CNT_ONE;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  // Read sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Read sequencer next state and read/pop/output strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_pop       = 1'b0;
    w_stb_nxt   = 1'b0;
    w_end_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pkt_cnt != '0) begin
          w_rd_en     = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        w_stb_nxt = 1'b1;
        if (w_rdata.last) begin
          w_pop       = 1'b1;
          w_state_nxt = END;
        end else begin
          w_rd_en = 1'b1;
        end
      end
      END: begin
        w_end_nxt   = 1'b1;
        w_state_nxt = (GAP == 0) ? IDLE : jxj_rx_pkg::GAP;
      end
      jxj_rx_pkg::GAP: begin
        if (r_gap_cnt == GAP_W'(GAP - 1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read pointer, gap counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr  <= '0;
      r_gap_cnt <= '0;
      out_data  <= '0;
      out_stb   <= 1'b0;
      out_end   <= 1'b0;
    end else begin
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (r_state == END)                  r_gap_cnt <= '0;
      else if (r_state == jxj_rx_pkg::GAP) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      out_data <= w_stb_nxt ? w_rdata.data : '0;
      out_stb  <= w_stb_nxt;
      out_end  <= w_end_nxt;
    end
  end

`ifdef JXJ_RX_FIFO_DROP_CNT_EN
  // Saturating count of discarded packets, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n)                             drop_count <= '0;
    else if (w_discard && drop_count != '1) drop_count <= drop_count + 8'd1;
  end
`endif

endmodule
